// File: rtl/mem_editor_master.sv
// Byte-stream command engine: parses read/write packets from the host byte
// channel, drives a single-port RAM and returns ack / read-data bytes.
module mem_editor_master #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA,
    S_ACCESS, S_CAPTURE, S_RSP, S_ERR_RSP
  } state_t;

  state_t             state_reg, state_next;
  logic               cmd_ready_reg;
  logic [7:0]         addr_hi_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [31:0]        wdata_reg;
  logic [31:0]        rdata_reg;
  logic [1:0]         cnt_reg;
  logic               is_write_reg;
  logic               addr_err_reg;

  logic               cmd_fire;
  logic               rsp_fire;
  logic [15:0]        full_addr;
  logic               addr_bad;

  assign cmd_fire  = cmd_valid & cmd_ready_reg;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign full_addr = {addr_hi_reg, cmd_data};
  assign addr_bad  = {16'd0, full_addr} >= 32'(DEPTH);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (cmd_fire)
                   state_next = (cmd_data == 8'h57 || cmd_data == 8'h52) ? S_ADDR_HI : S_ERR_RSP;
      S_ADDR_HI: if (cmd_fire) state_next = S_ADDR_LO;
      S_ADDR_LO: if (cmd_fire) begin
                   if (is_write_reg) state_next = S_DATA;
                   else              state_next = addr_bad ? S_ERR_RSP : S_ACCESS;
                 end
      S_DATA:    if (cmd_fire && cnt_reg == 2'd3)
                   state_next = addr_err_reg ? S_ERR_RSP : S_ACCESS;
      S_ACCESS:  state_next = is_write_reg ? S_RSP : S_CAPTURE;
      S_CAPTURE: state_next = S_RSP;
      S_RSP:     if (rsp_fire && (is_write_reg || cnt_reg == 2'd3)) state_next = S_IDLE;
      S_ERR_RSP: if (rsp_fire) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Datapath registers; cmd_ready is registered so it stays low while in reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready_reg <= 1'b0;
      addr_hi_reg   <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      cnt_reg       <= '0;
      is_write_reg  <= 1'b0;
      addr_err_reg  <= 1'b0;
    end else begin
      cmd_ready_reg <= (state_next == S_IDLE) || (state_next == S_ADDR_HI) ||
                       (state_next == S_ADDR_LO) || (state_next == S_DATA);
      case (state_reg)
        S_IDLE:    if (cmd_fire) is_write_reg <= (cmd_data == 8'h57);
        S_ADDR_HI: if (cmd_fire) addr_hi_reg <= cmd_data;
        S_ADDR_LO: if (cmd_fire) begin
                     addr_reg     <= full_addr[ADDR_W-1:0];
                     addr_err_reg <= addr_bad;
                     cnt_reg      <= '0;
                   end
        S_DATA:    if (cmd_fire) begin
                     wdata_reg <= {wdata_reg[23:0], cmd_data};
                     cnt_reg   <= cnt_reg + 2'd1;
                   end
        S_CAPTURE: begin
                     rdata_reg <= mem_readdata;
                     cnt_reg   <= '0;
                   end
        S_RSP:     if (rsp_fire) cnt_reg <= cnt_reg + 2'd1;
        default:   ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    cmd_ready      = cmd_ready_reg;
    mem_address    = addr_reg;
    mem_writedata  = wdata_reg;
    mem_byteenable = 4'hF;
    mem_chipselect = (state_reg == S_ACCESS);
    mem_write      = (state_reg == S_ACCESS) && is_write_reg;
    mem_clken      = (state_reg == S_ACCESS) || (state_reg == S_CAPTURE);
    rsp_valid      = (state_reg == S_RSP) || (state_reg == S_ERR_RSP);
    rsp_data       = 8'h00;
    if (state_reg == S_ERR_RSP) begin
      rsp_data = 8'h45;
    end else if (state_reg == S_RSP) begin
      if (is_write_reg) begin
        rsp_data = 8'h4B;
      end else begin
        case (cnt_reg)
          2'd0:    rsp_data = rdata_reg[31:24];
          2'd1:    rsp_data = rdata_reg[23:16];
          2'd2:    rsp_data = rdata_reg[15:8];
          default: rsp_data = rdata_reg[7:0];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_editor_master.sv
// Scoreboard bench for mem_editor_master: queued expected response bytes and
// write strobes are compared as the engine produces them.
module tb_mem_editor_master;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        cmd_data = 8'h00;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        rsp_data;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int first_rsp_cyc = 0;
  int rsp_idx = 0;
  int wr_idx = 0;
  int cs_cnt = 0;
  bit bp = 1'b0;

  logic [7:0]  exp_q[$];
  logic [47:0] exp_wr[$];
  logic [31:0] ram [0:32767];

  mem_editor_master #(.ADDR_W(ADDR_W), .DEPTH(32000)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Single-port RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      else           mem_readdata <= ram[mem_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response / strobe monitor; also owns rsp_ready
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_valid;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
      end
      rsp_ready = bp ? ~rsp_ready : 1'b1;
      if (rsp_valid && !prev_valid) first_rsp_cyc = cyc;
      if (rsp_valid) begin
        check("cmd_ready_during_rsp", 32'(cmd_ready), 32'd0);
        if (rsp_ready) begin
          if (rsp_idx < exp_q.size()) begin
            check("rsp_byte", 32'(rsp_data), 32'(exp_q[rsp_idx]));
            $display("rsp byte %0d: %h", rsp_idx, rsp_data);
          end else begin
            check("rsp_extra_byte_idx", 32'(rsp_idx), 32'(exp_q.size() - 1));
          end
          rsp_idx++;
        end
      end
      if (mem_chipselect) begin
        cs_cnt++;
        check("clken_in_access", 32'(mem_clken), 32'd1);
        check("byteenable", 32'(mem_byteenable), 32'hF);
        if (mem_write) begin
          if (wr_idx < exp_wr.size()) begin
            check("wr_addr", 32'(mem_address), 32'(exp_wr[wr_idx][47:32]));
            check("wr_data", mem_writedata, exp_wr[wr_idx][31:0]);
            $display("write strobe addr %h data %h", mem_address, mem_writedata);
          end else begin
            check("wr_extra_strobe_idx", 32'(wr_idx), 32'(exp_wr.size() - 1));
          end
          wr_idx++;
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_valid = rsp_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    accept_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while ((rsp_idx != exp_q.size() || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rsp_done", 32'(rsp_idx), 32'(exp_q.size()));
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input bit ok);
    int cs0;
    cs0 = cs_cnt;
    if (ok) exp_wr.push_back({addr, data});
    exp_q.push_back(ok ? 8'h4B : 8'h45);
    send_byte(8'h57);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
    wait_rsp();
    check("wr_latency", 32'(first_rsp_cyc - accept_cyc), ok ? 32'd2 : 32'd1);
    check("wr_cs_pulses", 32'(cs_cnt - cs0), ok ? 32'd1 : 32'd0);
    $display("write addr %h data %h ok %0d done", addr, data, ok);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [31:0] data, input bit ok);
    int cs0;
    cs0 = cs_cnt;
    if (ok) for (int i = 3; i >= 0; i--) exp_q.push_back(data[i*8 +: 8]);
    else    exp_q.push_back(8'h45);
    send_byte(8'h52);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    wait_rsp();
    if (!bp) check("rd_latency", 32'(first_rsp_cyc - accept_cyc), ok ? 32'd3 : 32'd1);
    check("rd_cs_pulses", 32'(cs_cnt - cs0), ok ? 32'd1 : 32'd0);
    $display("read addr %h ok %0d done", addr, ok);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_chipselect", 32'(mem_chipselect), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd0);
    check("rst_address", 32'(mem_address), 32'd0);
    check("rst_writedata", mem_writedata, 32'd0);
    check("rst_byteenable", 32'(mem_byteenable), 32'hF);
  endtask

  initial begin
    int cs0;
    #2;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    do_write(16'h0010, 32'hDEADBEEF, 1'b1);
    do_read(16'h0010, 32'hDEADBEEF, 1'b1);
    do_write(16'h7CFF, 32'h01020304, 1'b1);
    do_read(16'h7CFF, 32'h01020304, 1'b1);
    do_write(16'h7D00, 32'h55AA55AA, 1'b0);
    do_read(16'h8000, 32'h0, 1'b0);

    // Bad opcode, then the very next byte starts a fresh packet
    exp_q.push_back(8'h45);
    send_byte(8'h41);
    wait_rsp();
    check("bad_opcode_latency", 32'(first_rsp_cyc - accept_cyc), 32'd1);
    do_read(16'h0010, 32'hDEADBEEF, 1'b1);

    bp = 1'b1;
    do_read(16'h0010, 32'hDEADBEEF, 1'b1);
    bp = 1'b0;

    // Abort a write by reset after two data bytes
    do_write(16'h0020, 32'hCAFEF00D, 1'b1);
    cs0 = cs_cnt;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h11);
    send_byte(8'h22);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    check("abort_no_strobe", 32'(cs_cnt - cs0), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    do_read(16'h0020, 32'hCAFEF00D, 1'b1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
